// File: rtl/segment_transition_ctrl.sv
// Segment-switch controller for the modulation/STM sampler.
// Latches a transition request, waits for its trigger, switches the active
// read segment and tracks per-segment repetition (STOP / EXT auto-advance).
module segment_transition_ctrl #(
    parameter int unsigned NUM_SEGMENTS = 4,
    parameter int unsigned SEG_W        = $clog2(NUM_SEGMENTS),
    parameter int unsigned REP_W        = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          UPDATE,
    input  logic [7:0]                    REQ_SEGMENT,
    input  logic [7:0]                    TRANSITION_MODE,
    input  logic [63:0]                   TRANSITION_VALUE,
    input  logic [NUM_SEGMENTS*REP_W-1:0] REP,
    input  logic [63:0]                   SYS_TIME,
    input  logic [3:0]                    GPIO_IN,
    input  logic                          IDX_WRAP,
    output logic [SEG_W-1:0]              SEGMENT,
    output logic                          STOP,
    output logic                          PENDING,
    output logic                          DONE,
    output logic                          ERR
);

    localparam logic [7:0] MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] MODE_GPIO      = 8'h02;
    localparam logic [7:0] MODE_EXT       = 8'hF0;
    localparam logic [7:0] MODE_IMMEDIATE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        WAIT_TIME = 2'd2,
        WAIT_GPIO = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [SEG_W-1:0]   req_seg_q, req_seg_d;
    logic [63:0]        req_val_q, req_val_d;
    logic [REP_W-1:0]   cnt_q, cnt_d;
    logic               stop_q, stop_d;
    logic               pending_q, pending_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ext_auto_q, ext_auto_d;
    logic [3:0]         gpio_prev_q;

    logic [REP_W-1:0]   rep_cur;
    logic [REP_W-1:0]   cnt_inc;
    logic [SEG_W-1:0]   seg_next;
    logic [3:0]         gpio_rise;
    logic               mode_ok;
    logic               req_ok;
    logic               trigger;
    logic               loop_done;
    logic               do_switch;
    logic [SEG_W-1:0]   switch_seg;

    // Repeat count of the active segment, saturating loop increment, wrap-around successor
    always_comb begin
        rep_cur = '0;
        for (int unsigned k = 0; k < NUM_SEGMENTS; k++) begin
            if (seg_q == SEG_W'(k)) begin
                rep_cur = REP[k*REP_W +: REP_W];
            end
        end
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + REP_W'(1);
        seg_next  = (seg_q == SEG_W'(NUM_SEGMENTS - 1)) ? '0 : seg_q + SEG_W'(1);
        gpio_rise = GPIO_IN & ~gpio_prev_q;
        loop_done = IDX_WRAP && (rep_cur != '1) && (cnt_inc >= rep_cur + REP_W'(1));
    end

    // Request validation and per-state trigger selection
    always_comb begin
        mode_ok = 1'b0;
        trigger = 1'b0;
        case (TRANSITION_MODE)
            MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO,
            MODE_EXT, MODE_IMMEDIATE: mode_ok = 1'b1;
            default:                  mode_ok = 1'b0;
        endcase
        req_ok = UPDATE && mode_ok && (REQ_SEGMENT < 8'(NUM_SEGMENTS));
        case (state_q)
            WAIT_SYNC: trigger = IDX_WRAP;
            WAIT_TIME: trigger = (SYS_TIME >= req_val_q);
            WAIT_GPIO: trigger = gpio_rise[req_val_q[1:0]];
            default:   trigger = 1'b0;
        endcase
    end

    // Next-state and output logic; a valid UPDATE takes priority over any trigger
    always_comb begin
        state_d    = state_q;
        seg_d      = seg_q;
        req_seg_d  = req_seg_q;
        req_val_d  = req_val_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ext_auto_d = ext_auto_q;
        cnt_d      = IDX_WRAP ? cnt_inc : cnt_q;
        do_switch  = 1'b0;
        switch_seg = seg_q;

        if (req_ok) begin
            req_seg_d  = REQ_SEGMENT[SEG_W-1:0];
            req_val_d  = TRANSITION_VALUE;
            ext_auto_d = (TRANSITION_MODE == MODE_EXT);
            case (TRANSITION_MODE)
                MODE_SYNC_IDX, MODE_EXT: state_d = WAIT_SYNC;
                MODE_SYS_TIME:           state_d = WAIT_TIME;
                MODE_GPIO:               state_d = WAIT_GPIO;
                default: begin
                    do_switch  = 1'b1;
                    switch_seg = REQ_SEGMENT[SEG_W-1:0];
                end
            endcase
            if (!do_switch && loop_done) begin
                stop_d = 1'b1;
            end
        end else begin
            if (UPDATE) begin
                err_d = 1'b1;
            end
            if (trigger) begin
                do_switch  = 1'b1;
                switch_seg = req_seg_q;
            end else if (loop_done) begin
                if (ext_auto_q && (state_q == IDLE)) begin
                    do_switch  = 1'b1;
                    switch_seg = seg_next;
                end else begin
                    stop_d = 1'b1;
                end
            end
        end

        if (do_switch) begin
            seg_d   = switch_seg;
            cnt_d   = '0;
            stop_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
        end

        pending_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            seg_q       <= '0;
            req_seg_q   <= '0;
            req_val_q   <= '0;
            cnt_q       <= '0;
            stop_q      <= 1'b0;
            pending_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ext_auto_q  <= 1'b0;
            gpio_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            req_seg_q   <= req_seg_d;
            req_val_q   <= req_val_d;
            cnt_q       <= cnt_d;
            stop_q      <= stop_d;
            pending_q   <= pending_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ext_auto_q  <= ext_auto_d;
            gpio_prev_q <= GPIO_IN;
        end
    end

    assign SEGMENT = seg_q;
    assign STOP    = stop_q;
    assign PENDING = pending_q;
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctrl.sv
// Directed table-driven bench for segment_transition_ctrl (NUM_SEGMENTS=4).
module tb_segment_transition_ctrl;

    localparam int unsigned NSEG  = 4;
    localparam int unsigned SEGW  = 2;
    localparam int unsigned REPW  = 16;

    logic                  clk;
    logic                  rst;
    logic                  update;
    logic [7:0]            req_segment;
    logic [7:0]            transition_mode;
    logic [63:0]           transition_value;
    logic [NSEG*REPW-1:0]  rep;
    logic [63:0]           sys_time;
    logic [3:0]            gpio_in;
    logic                  idx_wrap;
    logic [SEGW-1:0]       segment;
    logic                  stop;
    logic                  pending;
    logic                  done;
    logic                  err;

    int n_checks = 0;
    int n_fail   = 0;

    segment_transition_ctrl #(
        .NUM_SEGMENTS(NSEG),
        .REP_W       (REPW)
    ) dut (
        .CLK             (clk),
        .RST             (rst),
        .UPDATE          (update),
        .REQ_SEGMENT     (req_segment),
        .TRANSITION_MODE (transition_mode),
        .TRANSITION_VALUE(transition_value),
        .REP             (rep),
        .SYS_TIME        (sys_time),
        .GPIO_IN         (gpio_in),
        .IDX_WRAP        (idx_wrap),
        .SEGMENT         (segment),
        .STOP            (stop),
        .PENDING         (pending),
        .DONE            (done),
        .ERR             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        upd;
        logic [7:0]  seg;
        logic [7:0]  mode;
        logic [63:0] val;
        logic        wrap;
        logic [63:0] t;
        logic [3:0]  gpio;
        logic [1:0]  e_seg;
        logic        e_stop;
        logic        e_pend;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic u, logic [7:0] s, logic [7:0] m, logic [63:0] v,
                                logic w, logic [63:0] t, logic [3:0] g,
                                logic [1:0] es, logic est, logic ep, logic ed, logic ee);
        vec_t r;
        r.upd = u; r.seg = s; r.mode = m; r.val = v; r.wrap = w; r.t = t; r.gpio = g;
        r.e_seg = es; r.e_stop = est; r.e_pend = ep; r.e_done = ed; r.e_err = ee;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] es, input logic est,
                           input logic ep, input logic ed, input logic ee);
        chk({tag, "_segment"}, 16'(segment), 16'(es));
        chk({tag, "_stop"},    16'(stop),    16'(est));
        chk({tag, "_pending"}, 16'(pending), 16'(ep));
        chk({tag, "_done"},    16'(done),    16'(ed));
        chk({tag, "_err"},     16'(err),     16'(ee));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        update = 1'b0; idx_wrap = 1'b0;
        req_segment = '0; transition_mode = '0; transition_value = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_in();
        sys_time = '0;
        gpio_in  = '0;
        // seg0 REP=1, seg1 infinite, seg2 REP=2, seg3 infinite
        rep = {16'hFFFF, 16'd2, 16'hFFFF, 16'd1};

        // reset state
        repeat (2) step();
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("post_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        //                u  seg    mode   val   w  time  gpio    SEG st pd dn er
        // repetition on seg0 (REP=1): STOP after second wrap
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd0, 0, 0, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd0, 0, 0, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd0, 1, 0, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd0, 1, 0, 0, 0));
        // SYNC_IDX to seg2, wrap five cycles after UPDATE
        vq.push_back(mk(1, 8'd2, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd0, 1, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd0, 1, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd2, 0, 0, 1, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd2, 0, 0, 0, 0));
        // SYS_TIME to seg1, target 1000, time ramps from 990
        vq.push_back(mk(1, 8'd1, 8'h01, 64'd1000, 0, 64'd990,  4'h0, 2'd2, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0,    0, 64'd998,  4'h0, 2'd2, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0,    0, 64'd999,  4'h0, 2'd2, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0,    0, 64'd1000, 4'h0, 2'd1, 0, 0, 1, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0,    0, 64'd1001, 4'h0, 2'd1, 0, 0, 0, 0));
        // target already in the past fires on the first waiting cycle
        vq.push_back(mk(1, 8'd1, 8'h01, 64'd500,  0, 64'd1002, 4'h0, 2'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0,    0, 64'd1003, 4'h0, 2'd1, 0, 0, 1, 0));
        // GPIO index 2 already high at acceptance, then low, then rising edge
        vq.push_back(mk(1, 8'd3, 8'h02, 64'd2, 0, 64'd0, 4'h4, 2'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h4, 2'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h2, 2'd1, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h6, 2'd3, 0, 0, 1, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd3, 0, 0, 0, 0));
        // rejected requests: segment out of range, undefined mode
        vq.push_back(mk(1, 8'd7, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd3, 0, 0, 0, 1));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd3, 0, 0, 0, 0));
        vq.push_back(mk(1, 8'd1, 8'h05, 64'd0, 0, 64'd0, 4'h0, 2'd3, 0, 0, 0, 1));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd3, 0, 0, 0, 0));
        // UPDATE coinciding with wrap in WAIT_SYNC replaces the request
        vq.push_back(mk(1, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd3, 0, 1, 0, 0));
        vq.push_back(mk(1, 8'd2, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd3, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd2, 0, 0, 1, 0));
        // triggering wrap not counted: seg2 REP=2 stops on the third later wrap
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd2, 0, 0, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd2, 0, 0, 0, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd2, 1, 0, 0, 0));
        // IMMEDIATE switch clears STOP
        vq.push_back(mk(1, 8'd0, 8'hFF, 64'd0, 0, 64'd0, 4'h0, 2'd0, 0, 0, 1, 0));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd0, 0, 0, 0, 0));
        // invalid UPDATE while pending leaves the pending request intact
        vq.push_back(mk(1, 8'd1, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd0, 0, 1, 0, 0));
        vq.push_back(mk(1, 8'd9, 8'h00, 64'd0, 0, 64'd0, 4'h0, 2'd0, 0, 1, 0, 1));
        vq.push_back(mk(0, 8'd0, 8'h00, 64'd0, 1, 64'd0, 4'h0, 2'd1, 0, 0, 1, 0));

        foreach (vq[i]) begin
            update           = vq[i].upd;
            req_segment      = vq[i].seg;
            transition_mode  = vq[i].mode;
            transition_value = vq[i].val;
            idx_wrap         = vq[i].wrap;
            sys_time         = vq[i].t;
            gpio_in          = vq[i].gpio;
            step();
            chk_all($sformatf("vec%0d", i), vq[i].e_seg, vq[i].e_stop,
                    vq[i].e_pend, vq[i].e_done, vq[i].e_err);
        end
        idle_in();
        sys_time = '0;
        gpio_in  = '0;

        // EXT auto-advance with all REP=0: 3,0,1,2,3 on successive wraps
        rep = '0;
        update = 1'b1; req_segment = 8'd3; transition_mode = 8'hF0;
        step();
        idle_in();
        chk_all("ext_accept", 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        idx_wrap = 1'b1;
        step();
        idx_wrap = 1'b0;
        chk_all("ext_first", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk_all($sformatf("ext_gap%0d", k), 2'(3 + k), 1'b0, 1'b0, 1'b0, 1'b0);
            idx_wrap = 1'b1;
            step();
            idx_wrap = 1'b0;
            chk_all($sformatf("ext_adv%0d", k), 2'(k), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        // non-EXT request disables auto-advance: next loop end sets STOP
        update = 1'b1; req_segment = 8'd3; transition_mode = 8'hFF;
        step();
        idle_in();
        chk_all("ext_off", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
        idx_wrap = 1'b1;
        step();
        idx_wrap = 1'b0;
        chk_all("ext_off_stop", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset asserted mid WAIT_TIME aborts without a switch
        update = 1'b1; req_segment = 8'd2; transition_mode = 8'h01;
        transition_value = 64'd5000; sys_time = 64'd100;
        step();
        idle_in();
        chk_all("rst_wait", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_all("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        sys_time = 64'd6000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("rst_after%0d", k), 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
